// File: rtl/sysid_reader_if.sv
// ---------------------------------------------------------------------------
// sysid_reader_if
//   Avalon-MM read channel between the system-ID checker (master) and the
//   sysid control slave.
//
//   address       master -> slave   word address (0 = ID, 1 = timestamp)
//   read          master -> slave   read request
//   waitrequest   slave  -> master  stall; request is held while high
//   readdata      slave  -> master  32-bit read data
//   readdatavalid slave  -> master  qualifies readdata
// ---------------------------------------------------------------------------
interface sysid_reader_if;
  logic        address;
  logic        read;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        readdatavalid;

  modport master (
    output address, read,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, read,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/sysid_reader.sv
// ---------------------------------------------------------------------------
// sysid_reader
//   Avalon-MM read master that reads the system-ID slave (word 0 = ID,
//   word 1 = build timestamp) on a start pulse, compares both words with
//   build-time expectations and reports pass / mismatch / timeout.
//
//   Ports
//     clock, reset   rising-edge clock, synchronous active-high reset
//     start          one-cycle pulse, ignored while busy
//     bus            Avalon-MM read master (sysid_reader_if.master)
//     busy           sequence in progress
//     done           one-cycle pulse at end of sequence (never with busy)
//     pass           sticky: both words matched, no timeout
//     id_mismatch    sticky: word 0 differed from EXPECTED_ID
//     ts_mismatch    sticky: word 1 differed from EXPECTED_TS
//     timeout        sticky: a read exceeded TIMEOUT_CYCLES
//     id_value       captured word 0
//     ts_value       captured word 1
//
//   Optional build macro SYSID_READER_AUTOSTART_EN: when defined, a check is
//   launched automatically on the first cycle after reset deasserts.
// ---------------------------------------------------------------------------
module sysid_reader #(
  parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS    = 32'd1386398321,
  parameter int unsigned TIMEOUT_CYCLES = 255   // 1..65535
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  sysid_reader_if.master        bus,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  id_mismatch,
  output logic                  ts_mismatch,
  output logic                  timeout,
  output logic [31:0]           id_value,
  output logic [31:0]           ts_value
);

  typedef enum logic [2:0] {
    IDLE,
    REQ_ID,
    WAIT_ID,
    REQ_TS,
    WAIT_TS,
    FINISH
  } state_e;

  // Counter value seen in the last permitted cycle of a read.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        pass_q, pass_d;
  logic        id_mm_q, id_mm_d;
  logic        ts_mm_q, ts_mm_d;
  logic        tmo_q, tmo_d;
  logic [31:0] id_value_q, id_value_d;
  logic [31:0] ts_value_q, ts_value_d;

  logic start_eff;
  logic in_req;
  logic in_read;
  logic is_ts;
  logic capture;

`ifdef SYSID_READER_AUTOSTART_EN
  // High only in the first cycle after reset releases.
  logic autostart_q;
  always_ff @(posedge clock) begin
    if (reset) autostart_q <= 1'b1;
    else       autostart_q <= 1'b0;
  end
  assign start_eff = start | autostart_q;
`else
  assign start_eff = start;
`endif

  assign in_req  = (state_q == REQ_ID) || (state_q == REQ_TS);
  assign in_read = in_req || (state_q == WAIT_ID) || (state_q == WAIT_TS);
  assign is_ts   = (state_q == REQ_TS) || (state_q == WAIT_TS);

  // Data is taken in WAIT_x, or in REQ_x on the very cycle the request is
  // accepted; any other readdatavalid is stray and dropped.
  assign capture = in_read && bus.readdatavalid && (!in_req || !bus.waitrequest);

  // NOTE: every combinational output gets a default first so no path through
  // the case statement leaves a value unassigned, which would infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pass_d     = pass_q;
    id_mm_d    = id_mm_q;
    ts_mm_d    = ts_mm_q;
    tmo_d      = tmo_q;
    id_value_d = id_value_q;
    ts_value_d = ts_value_q;

    unique case (state_q)
      IDLE: begin
        if (start_eff) begin
          state_d = REQ_ID;
          cnt_d   = '0;
          pass_d  = 1'b0;
          id_mm_d = 1'b0;
          ts_mm_d = 1'b0;
          tmo_d   = 1'b0;
        end
      end

      REQ_ID, WAIT_ID, REQ_TS, WAIT_TS: begin
        cnt_d = cnt_q + 16'd1;
        if (capture) begin
          if (is_ts) begin
            ts_value_d = bus.readdata;
            ts_mm_d    = (bus.readdata != EXPECTED_TS);
            state_d    = FINISH;
          end else begin
            id_value_d = bus.readdata;
            id_mm_d    = (bus.readdata != EXPECTED_ID);
            state_d    = REQ_TS;
            cnt_d      = '0;
          end
        end else if (cnt_q == TMO_LAST) begin
          // Give up on this read; the timestamp read is skipped entirely.
          tmo_d   = 1'b1;
          state_d = FINISH;
        end else if (in_req && !bus.waitrequest) begin
          state_d = is_ts ? WAIT_TS : WAIT_ID;
        end
      end

      FINISH: state_d = IDLE;

      default: state_d = IDLE;
    endcase

    // Resolve pass on the edge into FINISH so it is valid alongside done.
    if ((state_d == FINISH) && (state_q != FINISH)) begin
      pass_d = !(id_mm_d || ts_mm_d || tmo_d);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its _d value from before the edge, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      pass_q     <= 1'b0;
      id_mm_q    <= 1'b0;
      ts_mm_q    <= 1'b0;
      tmo_q      <= 1'b0;
      id_value_q <= '0;
      ts_value_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pass_q     <= pass_d;
      id_mm_q    <= id_mm_d;
      ts_mm_q    <= ts_mm_d;
      tmo_q      <= tmo_d;
      id_value_q <= id_value_d;
      ts_value_q <= ts_value_d;
    end
  end

  // Request outputs decode straight from the state register, so they stay
  // stable while stalled and drop on the edge that leaves REQ_x.
  assign bus.read    = in_req;
  assign bus.address = (state_q == REQ_TS);

  assign busy        = in_read;
  assign done        = (state_q == FINISH);
  assign pass        = pass_q;
  assign id_mismatch = id_mm_q;
  assign ts_mismatch = ts_mm_q;
  assign timeout     = tmo_q;
  assign id_value    = id_value_q;
  assign ts_value    = ts_value_q;

endmodule

// File: tb/tb_sysid_reader.sv
// ---------------------------------------------------------------------------
// tb_sysid_reader
//   Drives sysid_reader through directed and random read sequences against a
//   cycle-level slave, and compares with a reference that derives completion
//   cycle, read count and result flags arithmetically from per-read
//   wait/latency figures.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sysid_reader;

  localparam logic [31:0] EXP_ID = 32'h0000_0000;
  localparam logic [31:0] EXP_TS = 32'd1386398321;
  localparam int          TMO    = 8;
  localparam int          NEVER  = 1000;   // latency that never arrives

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        busy, done, pass, id_mismatch, ts_mismatch, timeout;
  logic [31:0] id_value, ts_value;

  sysid_reader_if bus ();

  sysid_reader #(
    .EXPECTED_ID    (EXP_ID),
    .EXPECTED_TS    (EXP_TS),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .bus         (bus),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .id_mismatch (id_mismatch),
    .ts_mismatch (ts_mismatch),
    .timeout     (timeout),
    .id_value    (id_value),
    .ts_value    (ts_value)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [31:0] ref_id_value, ref_ts_value;
  int          exp_done_cyc, exp_reads;
  logic        exp_pass, exp_idmm, exp_tsmm, exp_to;

  // Observations from one sequence
  int          obs_done_cyc, obs_dones, obs_reads, obs_unstable, obs_overlap;
  logic        obs_busy1;
  logic        obs_addr[$];
  logic        snap_pass, snap_idmm, snap_tsmm, snap_to;
  logic [31:0] snap_id, snap_ts, snap_rst;

  // Each read k: stalled w cycles, data l cycles after acceptance (0 = same
  // cycle). A read needs w+l+1 cycles; more than TMO means timeout.
  task automatic predict(input int w0, input int l0, input logic [31:0] d0,
                         input int w1, input int l1, input logic [31:0] d1);
    int          w[2];
    int          l[2];
    logic [31:0] d[2];
    int          s;
    w[0] = w0; l[0] = l0; d[0] = d0;
    w[1] = w1; l[1] = l1; d[1] = d1;
    s = 1;
    exp_reads = 0; exp_idmm = 0; exp_tsmm = 0; exp_to = 0;
    for (int k = 0; k < 2; k++) begin
      if (w[k] < TMO) exp_reads++;
      if (w[k] + l[k] + 1 > TMO) begin
        exp_to = 1;
        s = s + TMO;
        break;
      end
      if (k == 0) begin
        ref_id_value = d[k];
        exp_idmm     = (d[k] != EXP_ID);
      end else begin
        ref_ts_value = d[k];
        exp_tsmm     = (d[k] != EXP_TS);
      end
      s = s + w[k] + l[k] + 1;
    end
    exp_done_cyc = s;
    exp_pass     = !(exp_idmm || exp_tsmm || exp_to);
  endtask

  // Pulses start in cycle 0, then plays the slave cycle by cycle.
  // extra_start: cycle of a second start pulse (0 = none).
  // rst_cyc: cycle in which reset is driven (0 = none).
  task automatic run_seq(input int w0, input int l0, input logic [31:0] d0,
                         input int w1, input int l1, input logic [31:0] d1,
                         input int extra_start, input int rst_cyc);
    int          w[2];
    int          l[2];
    logic [31:0] d[2];
    int          rc, due, cur, pend_idx;
    bit          in_req, pend, prev_stall;
    logic        prev_addr;
    w[0] = w0; l[0] = l0; d[0] = d0;
    w[1] = w1; l[1] = l1; d[1] = d1;
    rc = 0; due = 0; cur = 0; pend_idx = 0;
    in_req = 0; pend = 0; prev_stall = 0; prev_addr = 1'b0;
    obs_done_cyc = -1; obs_dones = 0; obs_reads = 0; obs_unstable = 0;
    obs_overlap = 0; obs_busy1 = 1'b0; obs_addr.delete(); snap_rst = '1;
    snap_pass = 0; snap_idmm = 0; snap_tsmm = 0; snap_to = 0; snap_id = '0; snap_ts = '0;

    @(negedge clock);
    start = 1'b1;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clock);
      start = (n == extra_start);
      reset = (rst_cyc != 0) && (n == rst_cyc);
      if (n == 1) obs_busy1 = busy;
      if (done && busy) obs_overlap++;
      if (rst_cyc != 0 && n == rst_cyc + 1)
        snap_rst = {26'd0, busy | done | pass, id_mismatch, ts_mismatch, timeout,
                    bus.read, bus.address} | id_value | ts_value;
      if (done) begin
        obs_dones++;
        if (obs_done_cyc < 0) begin
          obs_done_cyc = n;
          snap_pass = pass; snap_idmm = id_mismatch; snap_tsmm = ts_mismatch;
          snap_to = timeout; snap_id = id_value; snap_ts = ts_value;
        end
      end
      // A stalled request may only change if it has just timed out.
      if (prev_stall && (!bus.read || bus.address != prev_addr) && rc != TMO)
        obs_unstable++;

      bus.waitrequest   = 1'b0;
      bus.readdatavalid = 1'b0;
      bus.readdata      = $urandom;
      if (in_req && !bus.read) in_req = 0;
      if (bus.read && !in_req) begin
        in_req = 1;
        rc     = 0;
        cur    = int'(bus.address);
      end
      prev_stall = 0;
      if (bus.read) begin
        rc++;
        if (rc <= w[cur]) begin
          bus.waitrequest = 1'b1;
          prev_stall      = 1;
          prev_addr       = bus.address;
        end else begin
          in_req = 0;
          obs_reads++;
          obs_addr.push_back(bus.address);
          pend     = 1;
          due      = n + l[cur];
          pend_idx = cur;
        end
      end
      if (pend && n == due) begin
        bus.readdatavalid = 1'b1;
        bus.readdata      = d[pend_idx];
        pend              = 0;
      end
      if (rst_cyc != 0 && n >= rst_cyc + 6) break;
      if (rst_cyc == 0 && obs_done_cyc > 0 && n >= obs_done_cyc + 3) break;
    end
    start = 1'b0;
    reset = 1'b0;
    bus.waitrequest   = 1'b0;
    bus.readdatavalid = 1'b0;
  endtask

  task automatic check_seq(input string name);
    check({name, ".done_cycle"}, obs_done_cyc, exp_done_cyc);
    check({name, ".reads"}, obs_reads, exp_reads);
    foreach (obs_addr[i]) check({name, ".read_addr"}, {31'd0, obs_addr[i]}, i);
    check({name, ".done_pulses"}, obs_dones, 1);
    check({name, ".done_busy_overlap"}, obs_overlap, 0);
    check({name, ".stall_stable"}, obs_unstable, 0);
    check({name, ".busy_cycle1"}, {31'd0, obs_busy1}, 1);
    check({name, ".pass"}, {31'd0, snap_pass}, {31'd0, exp_pass});
    check({name, ".id_mismatch"}, {31'd0, snap_idmm}, {31'd0, exp_idmm});
    check({name, ".ts_mismatch"}, {31'd0, snap_tsmm}, {31'd0, exp_tsmm});
    check({name, ".timeout"}, {31'd0, snap_to}, {31'd0, exp_to});
    check({name, ".id_value"}, snap_id, ref_id_value);
    check({name, ".ts_value"}, snap_ts, ref_ts_value);
    check({name, ".pass_sticky"}, {31'd0, pass}, {31'd0, exp_pass});
  endtask

  task automatic directed(input string name,
                          input int w0, input int l0, input logic [31:0] d0,
                          input int w1, input int l1, input logic [31:0] d1,
                          input int extra_start);
    predict(w0, l0, d0, w1, l1, d1);
    run_seq(w0, l0, d0, w1, l1, d1, extra_start, 0);
    check_seq(name);
  endtask

  initial begin
    int          w0, l0, w1, l1;
    logic [31:0] d0, d1;

    reset = 1'b1;
    start = 1'b0;
    bus.waitrequest   = 1'b0;
    bus.readdata      = '0;
    bus.readdatavalid = 1'b0;
    ref_id_value = '0;
    ref_ts_value = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;

    check("reset.flags", {26'd0, busy, done, pass, id_mismatch, ts_mismatch, timeout}, 0);
    check("reset.bus", {30'd0, bus.read, bus.address}, 0);
    check("reset.id_value", id_value, 0);
    check("reset.ts_value", ts_value, 0);

    directed("zero_wait", 0, 1, EXP_ID, 0, 1, EXP_TS, 0);
    directed("wait3", 3, 1, EXP_ID, 3, 1, EXP_TS, 0);
    directed("id_mismatch", 0, 1, 32'h0000_0001, 0, 1, EXP_TS, 0);
    directed("id_timeout", 0, NEVER, EXP_ID, 0, 1, EXP_TS, 0);
    directed("same_cycle_rdv", 0, 0, EXP_ID, 2, 0, EXP_TS, 0);
    directed("start_while_busy", 0, 1, EXP_ID, 1, 2, EXP_TS, 2);

    // Reset while in WAIT_TS (read1 accepted in cycle 3, data due cycle 7).
    run_seq(0, 1, EXP_ID, 0, 4, EXP_TS, 0, 5);
    ref_id_value = '0;
    ref_ts_value = '0;
    check("reset_mid.outputs", snap_rst, 0);
    check("reset_mid.no_done", obs_dones, 0);
    check("reset_mid.late_rdv_id", id_value, 0);
    check("reset_mid.late_rdv_ts", ts_value, 0);
    check("reset_mid.idle", {31'd0, busy}, 0);
    directed("after_reset", 0, 1, EXP_ID, 0, 1, EXP_TS, 0);

    for (int i = 0; i < 40; i++) begin
      w0 = ($urandom_range(0, 9) == 9) ? 9 : int'($urandom_range(0, 3));
      w1 = ($urandom_range(0, 9) == 9) ? 9 : int'($urandom_range(0, 3));
      l0 = ($urandom_range(0, 7) == 0) ? NEVER : int'($urandom_range(0, 3));
      l1 = ($urandom_range(0, 7) == 0) ? NEVER : int'($urandom_range(0, 3));
      d0 = ($urandom_range(0, 3) == 0) ? $urandom : EXP_ID;
      d1 = ($urandom_range(0, 3) == 0) ? $urandom : EXP_TS;
      directed("random", w0, l0, d0, w1, l1, d1, 0);

      // Stray readdatavalid while idle must not disturb captured values.
      @(negedge clock);
      bus.readdatavalid = 1'b1;
      bus.readdata      = $urandom;
      @(negedge clock);
      bus.readdatavalid = 1'b0;
      @(negedge clock);
      check("stray_idle.id_value", id_value, ref_id_value);
      check("stray_idle.ts_value", ts_value, ref_ts_value);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sysid_reader.md
Name: sysid_reader

Overview:
- Avalon-MM read master that queries the system-ID control slave and checks its contents against build-time expectations.
- On `start`, it reads word 0 (system ID) and then word 1 (build timestamp), captures both, compares them with the expected values, and reports pass/fail/timeout.
- Sits between boot/reset-sequencing logic and the sysid slave. It gates software bring-up on a matching hardware image.

Parameters:
- EXPECTED_ID, 32'h00000000, value word 0 must return.
- EXPECTED_TS, 32'd1386398321, value word 1 must return.
- TIMEOUT_CYCLES, 255, max cycles per read from request assertion to readdatavalid; range 1..65535.

Ports:
- clock  input  1  system clock; all logic rising-edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a check sequence; ignored while busy.
- address  output  1  Avalon word address to sysid slave (0 = ID, 1 = timestamp).
- read  output  1  Avalon read request.
- waitrequest  input  1  slave stall; request held while high.
- readdata  input  32  slave read data.
- readdatavalid  input  1  qualifies readdata; at most one per accepted read.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse at end of sequence.
- pass  output  1  sticky; both words matched on the last sequence.
- id_mismatch  output  1  sticky; word 0 differed from EXPECTED_ID.
- ts_mismatch  output  1  sticky; word 1 differed from EXPECTED_TS.
- timeout  output  1  sticky; a read exceeded TIMEOUT_CYCLES.
- id_value  output  32  captured word 0.
- ts_value  output  32  captured word 1.

Behaviour:
- Reset (sync, active-high):
  - state = IDLE.
  - address, read, busy, done, pass, id_mismatch, ts_mismatch, timeout = 0.
  - id_value, ts_value = 0.
  - Timeout counter = 0.
- States: IDLE, REQ_ID, WAIT_ID, REQ_TS, WAIT_TS, FINISH.
- IDLE:
  - start=1 -> REQ_ID.
  - On the same edge: clear pass/id_mismatch/ts_mismatch/timeout and set busy=1.
- REQ_ID:
  - read=1, address=0.
  - Request accepted on a cycle with read=1 and waitrequest=0; then go to WAIT_ID and drop read the next cycle.
  - While waitrequest=1, read and address hold stable.
- WAIT_ID:
  - read=0.
  - On readdatavalid=1: id_value <= readdata; id_mismatch <= (readdata != EXPECTED_ID); go to REQ_TS.
- REQ_TS / WAIT_TS: identical to REQ_ID / WAIT_ID with address=1, capturing into ts_value and ts_mismatch.
- FINISH (one cycle):
  - done=1, busy=0.
  - pass=1 iff no mismatch and no timeout.
  - Return to IDLE.
- Readdatavalid in the same cycle as acceptance:
  - Must be honoured; data is captured in that cycle.
  - The next state skips WAIT_x (REQ_ID -> REQ_TS, REQ_TS -> FINISH).
- Timeout counter:
  - Clears on entry to each REQ_x state.
  - Increments every cycle in REQ_x and WAIT_x.
  - Reaching TIMEOUT_CYCLES without capture sets timeout=1, deasserts read, and goes to FINISH.
  - The ts read is skipped after an ID timeout; ts_value keeps its old value.
- Minimum sequence latency with waitrequest=0 and readdatavalid one cycle after acceptance:
  - start edge -> done pulse = 5 cycles.
  - Reads issue on cycles 1 and 3.
- Stray inputs:
  - start while busy: ignored, no queueing.
  - readdatavalid outside WAIT_x or accepted REQ_x: ignored.
- Reset mid-sequence:
  - Abort immediately, read drops on the next edge, all outputs return to reset values.
  - A late readdatavalid after reset falls under the stray-input rule above.
- Sticky flags hold until the next accepted start or reset.
- done is never high in the same cycle as busy.

Optional Feature:
- Macro: SYSID_READER_AUTOSTART_EN.
- Defined: an internal start is generated on the first cycle after reset deasserts, so a check runs without an external pulse. The external start port remains functional afterwards.
- Not defined: checks run only on the external start pulse; after reset the block idles with all flags 0.

Test Plan:
- Zero-wait slave returning 0 then 1386398321, start pulse:
  - read seen at address 0 then 1.
  - done 5 cycles after start; pass=1, id_value=0, ts_value=1386398321.
- waitrequest held high 3 cycles on each read:
  - read/address stable throughout.
  - done at 11 cycles; pass=1.
- Slave returns 32'h00000001 for word 0:
  - id_mismatch=1, ts_mismatch=0, pass=0, id_value=1.
- readdatavalid never asserted, TIMEOUT_CYCLES=8:
  - timeout=1 after 8 cycles in the ID read; no address-1 read issued; done pulse; pass=0.
- Reset asserted in WAIT_TS:
  - next cycle all outputs 0 and state IDLE.
  - a subsequent readdatavalid is ignored; a new start completes with pass=1.
- start pulsed again while busy:
  - ignored; exactly two reads and one done occur.
